// File: rtl/cls_seq_adder64.sv
// cls_seq_adder64 -- bit-serial-by-slice adder/subtractor.
// Operands are latched once. One 16-bit slice is then added per clock,
// starting with the least significant slice, so a result takes CHUNKS
// cycles. The result is held until the consumer takes it. Only one
// transaction is in flight, and the block holds no operand buffer.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready only while idle)
//   a, b                operands, W = 16*CHUNKS bits
//   carry_start         carry into slice 0 (add only)
//   sub                 1: a - b (b inverted, carry-in forced to 1)
//   out_valid/out_ready result handshake (out_valid only while done)
//   sum, carry_out      W-bit result and carry out of the MSB
//                       (sub: 1 = no borrow)
//   overflow            two's-complement signed overflow

// One 16-bit slice. cmsb is the carry into bit 15 of the slice.
// It is needed to derive signed overflow from the top slice.
module cls_slice_add16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout,
  output logic        cmsb
);
  logic [16:0] full;
  logic [15:0] low;

  assign full = {1'b0, x} + {1'b0, y} + {16'd0, cin};
  assign low  = {1'b0, x[14:0]} + {1'b0, y[14:0]} + {15'd0, cin};
  assign s    = full[15:0];
  assign cout = full[16];
  assign cmsb = low[15];
endmodule

module cls_seq_adder64 #(
  parameter int CHUNKS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*CHUNKS-1:0] a,
  input  logic [16*CHUNKS-1:0] b,
  input  logic                 carry_start,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*CHUNKS-1:0] sum,
  output logic                 carry_out,
  output logic                 overflow
);
  localparam int W  = 16 * CHUNKS;
  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   a_r, b_r;
  logic           carry;
  logic [IW-1:0]  idx;
  logic [IW+3:0]  base;     // bit offset of the current slice
  logic           last;
  logic [15:0]    sl_s;
  logic           sl_c, sl_cm;

  assign base      = {idx, 4'b0000};
  assign last      = (idx == IW'(CHUNKS - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  cls_slice_add16 u_slice (
    .x    (a_r[base +: 16]),
    .y    (b_r[base +: 16]),
    .cin  (carry),
    .s    (sl_s),
    .cout (sl_c),
    .cmsb (sl_cm)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = CALC;
      CALC:    if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= a;
          // Subtraction is a + ~b + 1, so the borrow becomes a carry.
          b_r   <= sub ? ~b : b;
          carry <= sub ? 1'b1 : carry_start;
          idx   <= '0;
        end
        CALC: begin
          sum[base +: 16] <= sl_s;
          carry           <= sl_c;
          idx             <= idx + IW'(1);
          if (last) begin
            carry_out <= sl_c;
            overflow  <= sl_c ^ sl_cm;
            // Clear explicitly, because CHUNKS need not be a power of two.
            idx       <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cls_seq_adder64.sv
module tb_cls_seq_adder64;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic         carry_start = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, carry_out, overflow;
  logic [W-1:0] sum;

  int checks = 0;
  int failures = 0;

  cls_seq_adder64 #(.CHUNKS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_start(carry_start), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference: whole-word arithmetic. The result is {overflow, carry_out, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, y,
                                         input logic cs, sb);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         ov;
    full = sb ? ({1'b0, x} + {1'b0, ~y} + (W+1)'(1))
              : ({1'b0, x} + {1'b0, y} + (W+1)'(cs));
    s = full[W-1:0];
    if (sb) ov = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
    else    ov = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    return {ov, full[W], s};
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Presents one operand set in IDLE and scrambles the inputs after accept.
  // It returns the number of edges until out_valid, capped at 20.
  task automatic start_txn(input logic [W-1:0] ta, tb_, input logic tcs, tsub,
                           output int lat);
    @(negedge clk);
    a = ta; b = tb_; carry_start = tcs; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = rnd64(); b = rnd64(); carry_start = $urandom; sub = $urandom;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_txn();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 ||
        carry_out !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset: rdy=%b vld=%b sum=%h co=%b ov=%b want 1 0 0 0 0",
               in_ready, out_valid, sum, carry_out, overflow);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic cs, sb;
    logic [W-1:0] s;
    logic co, ov;
  } vec_t;

  task automatic test_directed();
    vec_t v [7];
    int   lat;
    v[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0};
    v[1] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h1_0000, 1'b0, 1'b0};
    v[2] = '{64'h0000_0000_0000_FFFF, 64'd0, 1'b1, 1'b0, 64'h1_0000, 1'b0, 1'b0};
    v[3] = '{64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    v[4] = '{64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0};
    v[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    v[6] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    foreach (v[i]) begin
      start_txn(v[i].a, v[i].b, v[i].cs, v[i].sb, lat);
      checks++;
      if (lat !== 4 || sum !== v[i].s || carry_out !== v[i].co ||
          overflow !== v[i].ov) begin
        failures++;
        $display("FAIL directed[%0d]: lat=%0d sum=%h co=%b ov=%b want 4 %h %b %b",
                 i, lat, sum, carry_out, overflow, v[i].s, v[i].co, v[i].ov);
      end
      take_txn();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic         rcs, rsb;
    logic [W+1:0] exp;
    int           lat;
    for (int n = 0; n < 40; n++) begin
      ra = rnd64(); rb = rnd64(); rcs = $urandom; rsb = $urandom;
      if (n % 8 == 0) rb = ~ra;              // long carry/borrow chains
      exp = model(ra, rb, rcs, rsb);
      start_txn(ra, rb, rcs, rsb, lat);
      checks++;
      if (lat !== 4 || {overflow, carry_out, sum} !== exp) begin
        failures++;
        $display("FAIL random[%0d]: a=%h b=%h cs=%b sub=%b lat=%0d got ov=%b co=%b sum=%h want ov=%b co=%b sum=%h",
                 n, ra, rb, rcs, rsb, lat, overflow, carry_out, sum,
                 exp[W+1], exp[W], exp[W-1:0]);
      end
      take_txn();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2;
    logic [W+1:0] e1, e2;
    int           lat;
    a1 = rnd64(); b1 = rnd64(); a2 = rnd64(); b2 = rnd64();
    e1 = model(a1, b1, 1'b0, 1'b0);
    e2 = model(a2, b2, 1'b0, 1'b1);
    start_txn(a1, b1, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 4 || {overflow, carry_out, sum} !== e1) begin
      failures++;
      $display("FAIL bp_first: lat=%0d got %h want %h", lat,
               {overflow, carry_out, sum}, e1);
    end
    // Hold off the consumer while a new operand set is being offered.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; a = a2; b = b2; sub = 1'b1; carry_start = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {overflow, carry_out, sum} !== e1) begin
        failures++;
        $display("FAIL bp_hold[%0d]: vld=%b rdy=%b res=%h want 1 0 %h",
                 k, out_valid, in_ready, {overflow, carry_out, sum}, e1);
      end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    // in_valid is still high, so the very next edge re-accepts.
    @(posedge clk); #1;
    in_valid = 1'b0; a = rnd64(); b = rnd64();
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_reaccept: rdy=%b want 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 4 || {overflow, carry_out, sum} !== e2) begin
      failures++;
      $display("FAIL bp_second: lat=%0d got %h want %h", lat,
               {overflow, carry_out, sum}, e2);
    end
    take_txn();
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    @(negedge clk);
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h1111_1111_1111_1111;
    sub = 1'b0; carry_start = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;      // two slices done
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== '0) begin
      failures++;
      $display("FAIL mid_reset: vld=%b rdy=%b sum=%h want 0 1 0",
               out_valid, in_ready, sum);
    end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_abort: out_valid seen=%b want 0", seen);
    end
    start_txn(64'd3, 64'd4, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 4 || sum !== 64'd7 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_next: lat=%0d sum=%h co=%b ov=%b want 4 7 0 0",
               lat, sum, carry_out, overflow);
    end
    take_txn();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cls_seq_adder64.md
CLS_SEQ_ADDER64 -- requirements
Module: cls_seq_adder64

Interface
REQ-001 Parameter: CHUNKS, default 4, number of 16-bit slices; operand width W = 16*CHUNKS.
REQ-002 The block SHALL have exactly one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  W  operand A.
REQ-008 b  input  W  operand B.
REQ-009 carry_start  input  1  carry into slice 0 (add mode only).
REQ-010 sub  input  1  1 = compute a - b; carry_start ignored.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 sum  output  W  result.
REQ-014 carry_out  output  1  carry out of MSB slice (sub mode: 1 = no borrow).
REQ-015 overflow  output  1  two's-complement signed overflow of the result.

Function
REQ-016 The block SHALL be a three-state FSM: IDLE, CALC, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 IDLE, in_valid=1: latch a, latch b (bitwise-inverted if sub=1), set carry = sub ? 1 : carry_start, set chunk index = 0, go to CALC.
REQ-019 CALC: each cycle compute {c,s} = A[idx] + B[idx] + carry over one 16-bit slice, write s into sum[idx], set carry = c, and increment idx.
REQ-020 CALC: after the cycle with idx = CHUNKS-1, register carry_out and overflow, then go to DONE.
REQ-021 overflow SHALL equal the carry into the MSB XOR the carry out of the MSB of the final slice.
REQ-022 Latency: out_valid SHALL rise exactly CHUNKS cycles after the accepting edge (4 for the default).
REQ-023 DONE: sum, carry_out and overflow SHALL hold stable while out_ready=0; on out_ready=1, go to IDLE on that edge.
REQ-024 in_valid outside IDLE SHALL be ignored; no operands are buffered and there is no overlap between transactions.
REQ-025 Operand inputs SHALL be sampled only on the accepting edge; later changes do not affect the result.
REQ-026 sum SHALL be exact modulo 2^W; carry chains wrap across all slices (all-ones + 1 gives 0 with carry_out 1).
REQ-027 If out_ready=1 on the first DONE cycle, the result is taken in one cycle; the earliest re-accept is the following cycle.

Reset
REQ-028 While rst=1: state = IDLE, in_ready = 1, out_valid = 0, sum = 0, carry_out = 0, overflow = 0, idx = 0, carry = 0.
REQ-029 rst asserted mid-CALC or in DONE SHALL abort the transaction; the partial result is discarded and never presented.
REQ-030 The first edge after rst deasserts SHALL be able to accept a new transaction.

Verification
REQ-031 Add: a=0xFFFF_FFFF_FFFF_FFFF, b=1, carry_start=0 -> sum=0, carry_out=1, overflow=0, out_valid 4 cycles after accept.
REQ-032 Cross-slice carry: a=0x0000_0000_0000_FFFF, b=1 -> sum=0x0000_0000_0001_0000, carry_out=0; repeat with carry_start=1 and b=0 -> same sum.
REQ-033 Subtract: sub=1, a=5, b=7 -> sum=0xFFFF_FFFF_FFFF_FFFE, carry_out=0, overflow=0; a=7, b=5 -> sum=2, carry_out=1.
REQ-034 Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000, overflow=1, carry_out=0.
REQ-035 Backpressure: out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands -> outputs stable, in_ready=0, new operands not taken; out_ready=1 -> IDLE, then new operands accepted.
REQ-036 Reset in CALC after 2 slices -> out_valid stays 0, in_ready=1 after reset; next transaction a=3, b=4 -> sum=7.
